// File: rtl/team_score_keeper.sv
// team_score_keeper: per-team goal/snitch scoring FSM with goal lockout and saturating score
module team_score_keeper #(
  parameter int GOAL_POINTS    = 10,
  parameter int SNITCH_POINTS  = 150,
  parameter int MAX_SCORE      = 999,
  parameter int LOCKOUT_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        goal_in,
  input  logic        snitch_in,
  input  logic        tick,
  output logic [13:0] score,
  output logic        playing_reg,
  output logic        score_inc,
  output logic        game_over
);
  localparam int CW = LOCKOUT_FRAMES > 1 ? $clog2(LOCKOUT_FRAMES + 1) : 1;
  typedef enum logic [1:0] {IDLE, PLAYING, LOCKOUT, GAME_OVER} state_t;
  state_t        r_state;
  logic          r_goal_q;
  logic          r_snitch_q;
  logic [CW-1:0] r_cnt;
  logic [13:0]   r_score;
  logic          r_playing;
  logic          r_inc;
  logic          r_game_over;
  logic          w_goal_acc;
  logic          w_snitch_acc;
  logic [14:0]   w_sum;
  logic [13:0]   w_next;
  assign score       = r_score;
  assign playing_reg = r_playing;
  assign score_inc   = r_inc;
  assign game_over   = r_game_over;
  // accepted events and the saturating next score; goals only count outside lockout
  always_comb begin
    w_goal_acc   = (r_state == PLAYING) & goal_in & ~r_goal_q;
    w_snitch_acc = (r_state == PLAYING || r_state == LOCKOUT) & snitch_in & ~r_snitch_q;
    w_sum        = {1'b0, r_score} + (w_goal_acc ? 15'(GOAL_POINTS) : 15'd0)
                 + (w_snitch_acc ? 15'(SNITCH_POINTS) : 15'd0);
    w_next       = w_sum > 15'(MAX_SCORE) ? 14'(MAX_SCORE) : w_sum[13:0];
  end
  // edge-detect history, updated every cycle regardless of state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_goal_q   <= 1'b0;
      r_snitch_q <= 1'b0;
    end else begin
      r_goal_q   <= goal_in;
      r_snitch_q <= snitch_in;
    end
  end
  // match FSM: start wins over events, snitch ends the match, goals arm the lockout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_score     <= '0;
      r_cnt       <= '0;
      r_playing   <= 1'b0;
      r_inc       <= 1'b0;
      r_game_over <= 1'b0;
    end else if (start) begin
      r_state     <= PLAYING;
      r_score     <= '0;
      r_cnt       <= '0;
      r_playing   <= 1'b1;
      r_inc       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_inc <= w_goal_acc | w_snitch_acc;
      if (w_goal_acc | w_snitch_acc) r_score <= w_next;
      if (w_snitch_acc) begin
        r_state     <= GAME_OVER;
        r_playing   <= 1'b0;
        r_game_over <= 1'b1;
      end else if (w_goal_acc && LOCKOUT_FRAMES != 0) begin
        r_state <= LOCKOUT;
        r_cnt   <= CW'(LOCKOUT_FRAMES);
      end else if (r_state == LOCKOUT && tick) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_state <= PLAYING;
      end
    end
  end
endmodule

// File: tb/tb_team_score_keeper.sv
// tb_team_score_keeper: scoreboard bench for default and zero-lockout scorekeepers
module tb_team_score_keeper;
  logic        clk = 0;
  logic        reset = 0;
  logic        tick = 0;
  logic        start_a = 0, goal_a = 0, snitch_a = 0;
  logic        start_b = 0, goal_b = 0, snitch_b = 0;
  logic [13:0] score_a, score_b;
  logic        playing_a, playing_b, inc_a, inc_b, go_a, go_b;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_inc_a = 0;
  int          n_inc_b = 0;
  int          q_a[$];
  int          q_b[$];

  team_score_keeper dut_a (
    .clk(clk), .reset(reset), .start(start_a), .goal_in(goal_a), .snitch_in(snitch_a),
    .tick(tick), .score(score_a), .playing_reg(playing_a), .score_inc(inc_a), .game_over(go_a)
  );
  team_score_keeper #(.LOCKOUT_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .goal_in(goal_b), .snitch_in(snitch_b),
    .tick(tick), .score(score_b), .playing_reg(playing_b), .score_inc(inc_b), .game_over(go_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_a) begin
      int e;
      n_inc_a++;
      n_total++;
      if (q_a.size() == 0) $display("FAIL a_unexpected_inc score=%0d expected no pulse", score_a);
      else begin
        e = q_a.pop_front();
        if (score_a !== 14'(e)) $display("FAIL a_score_on_inc got=%0d exp=%0d", score_a, e);
        else n_pass++;
      end
    end
    if (inc_b) begin
      int e;
      n_inc_b++;
      n_total++;
      if (q_b.size() == 0) $display("FAIL b_unexpected_inc score=%0d expected no pulse", score_b);
      else begin
        e = q_b.pop_front();
        if (score_b !== 14'(e)) $display("FAIL b_score_on_inc got=%0d exp=%0d", score_b, e);
        else n_pass++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1;
      @(negedge clk) tick = 0;
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
  endtask

  task automatic goal_rise_a();
    @(negedge clk) goal_a = 1;
    @(negedge clk) goal_a = 0;
    @(negedge clk);
  endtask

  task automatic goal_rise_b();
    @(negedge clk) goal_b = 1;
    @(negedge clk) goal_b = 0;
  endtask

  task automatic test_reset();
    cyc(2);
    n_total++;
    if ({score_a, playing_a, go_a, inc_a} !== 17'd0)
      $display("FAIL reset_hold score=%0d playing=%0b go=%0b inc=%0b exp all 0", score_a, playing_a, go_a, inc_a);
    else n_pass++;
    @(negedge clk) reset = 1;
    cyc(2);
    n_total++;
    if ({score_a, playing_a, go_a} !== 16'd0)
      $display("FAIL idle_after_reset score=%0d playing=%0b go=%0b exp 0/0/0", score_a, playing_a, go_a);
    else n_pass++;
    repeat (3) goal_rise_a();
    n_total++;
    if (n_inc_a !== 0 || score_a !== 14'd0) $display("FAIL idle_goal_ignored incs=%0d score=%0d exp 0/0", n_inc_a, score_a);
    else n_pass++;
  endtask

  task automatic test_goal_lockout();
    int base;
    pulse_start_a();
    n_total++;
    if (playing_a !== 1'b1 || score_a !== 14'd0) $display("FAIL start_playing playing=%0b score=%0d exp 1/0", playing_a, score_a);
    else n_pass++;
    base = n_inc_a;
    @(negedge clk) goal_a = 1;
    q_a.push_back(10);
    cyc(100);
    n_total++;
    if (n_inc_a - base !== 1 || score_a !== 14'd10) $display("FAIL held_goal incs=%0d score=%0d exp 1/10", n_inc_a - base, score_a);
    else n_pass++;
    @(negedge clk) goal_a = 0;
    ticks(5);
    goal_rise_a();
    n_total++;
    if (score_a !== 14'd10) $display("FAIL lockout_5_ticks score=%0d exp 10", score_a);
    else n_pass++;
    ticks(24);
    goal_rise_a();
    n_total++;
    if (score_a !== 14'd10 || playing_a !== 1'b1) $display("FAIL lockout_29_ticks score=%0d playing=%0b exp 10/1", score_a, playing_a);
    else n_pass++;
    ticks(1);
    q_a.push_back(20);
    goal_rise_a();
    n_total++;
    if (score_a !== 14'd20) $display("FAIL after_30_ticks score=%0d exp 20", score_a);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int base;
    pulse_start_b();
    base = n_inc_b;
    for (int i = 0; i < 102; i++) begin
      q_b.push_back((i + 1) * 10 > 999 ? 999 : (i + 1) * 10);
      goal_rise_b();
    end
    @(negedge clk);
    n_total++;
    if (n_inc_b - base !== 102 || score_b !== 14'd999 || playing_b !== 1'b1)
      $display("FAIL saturation incs=%0d score=%0d playing=%0b exp 102/999/1", n_inc_b - base, score_b, playing_b);
    else n_pass++;
  endtask

  task automatic test_snitch();
    int base;
    pulse_start_b();
    for (int i = 1; i <= 4; i++) begin
      q_b.push_back(10 * i);
      goal_rise_b();
    end
    @(negedge clk) snitch_b = 1;
    q_b.push_back(190);
    @(negedge clk);
    n_total++;
    if (go_b !== 1'b1 || playing_b !== 1'b0 || score_b !== 14'd190)
      $display("FAIL snitch_end go=%0b playing=%0b score=%0d exp 1/0/190", go_b, playing_b, score_b);
    else n_pass++;
    snitch_b = 0;
    @(negedge clk);
    n_total++;
    if (inc_b !== 1'b0) $display("FAIL snitch_inc_width inc=%0b exp 0", inc_b);
    else n_pass++;
    base = n_inc_b;
    goal_rise_b();
    @(negedge clk) snitch_b = 1;
    @(negedge clk) snitch_b = 0;
    cyc(2);
    n_total++;
    if (score_b !== 14'd190 || n_inc_b !== base || go_b !== 1'b1)
      $display("FAIL game_over_frozen score=%0d incs=%0d go=%0b exp 190/0/1", score_b, n_inc_b - base, go_b);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int base;
    pulse_start_a();
    @(negedge clk) begin goal_a = 1; snitch_a = 1; end
    q_a.push_back(160);
    @(negedge clk) begin goal_a = 0; snitch_a = 0; end
    n_total++;
    if (score_a !== 14'd160 || go_a !== 1'b1) $display("FAIL goal_and_snitch score=%0d go=%0b exp 160/1", score_a, go_a);
    else n_pass++;
    cyc(2);
    base = n_inc_a;
    @(negedge clk) begin start_a = 1; goal_a = 1; snitch_a = 1; end
    @(negedge clk) begin start_a = 0; goal_a = 0; snitch_a = 0; end
    n_total++;
    if (score_a !== 14'd0 || playing_a !== 1'b1 || go_a !== 1'b0 || inc_a !== 1'b0 || n_inc_a !== base)
      $display("FAIL start_priority score=%0d playing=%0b go=%0b inc=%0b exp 0/1/0/0", score_a, playing_a, go_a, inc_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start_a();
    for (int k = 1; k <= 3; k++) begin
      q_a.push_back(10 * k);
      goal_rise_a();
      if (k < 3) ticks(30);
    end
    n_total++;
    if (score_a !== 14'd30 || playing_a !== 1'b1) $display("FAIL pre_reset score=%0d playing=%0b exp 30/1", score_a, playing_a);
    else n_pass++;
    @(negedge clk);
    #2 reset = 0;
    #1;
    n_total++;
    if ({score_a, playing_a, go_a, inc_a} !== 17'd0)
      $display("FAIL async_reset score=%0d playing=%0b go=%0b inc=%0b exp all 0", score_a, playing_a, go_a, inc_a);
    else n_pass++;
    @(negedge clk) reset = 1;
    cyc(3);
    n_total++;
    if (playing_a !== 1'b0 || score_a !== 14'd0) $display("FAIL idle_after_mid_reset playing=%0b score=%0d exp 0/0", playing_a, score_a);
    else n_pass++;
    pulse_start_a();
    q_a.push_back(10);
    goal_rise_a();
    n_total++;
    if (score_a !== 14'd10) $display("FAIL goal_after_reset score=%0d exp 10", score_a);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_goal_lockout();
    test_saturation();
    test_snitch();
    test_simultaneous();
    test_reset_mid();
    cyc(3);
    n_total++;
    if (q_a.size() != 0 || q_b.size() != 0) $display("FAIL missing_pulses left_a=%0d left_b=%0d exp 0/0", q_a.size(), q_b.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
